// File: rtl/pipe_pkg.sv
// Shared types for the execute-to-memory elastic pipeline register.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_REG_W  = 5;

   // Occupancy of the two-entry stage
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // Writeback mux select encodings
   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   // One in-flight instruction as seen by the Memory stage
   typedef struct packed {
      logic [PIPE_DATA_W-1:0] alu_result;
      logic [PIPE_DATA_W-1:0] write_data;
      logic [PIPE_REG_W-1:0]  rd;
      logic [PIPE_DATA_W-1:0] pc_plus4;
      logic                   reg_write;
      logic                   mem_write;
      logic [1:0]             result_src;
      logic [2:0]             funct3;
   } exc_mem_t;

endpackage

// File: rtl/exc_mem_slot.sv
// Single entry holder: loadable, with a clear that only kills the control bits.
module exc_mem_slot
   import pipe_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     i_load,
   input  logic     i_clr_ctrl,
   input  exc_mem_t i_d,
   output exc_mem_t o_q
);

   exc_mem_t r_q;

   // Reset wipes the whole entry; a squash only drops the side-effect bits
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_clr_ctrl) begin
         r_q.reg_write <= 1'b0;
         r_q.mem_write <= 1'b0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_exc_mem_elastic.sv
// Execute-to-memory pipeline register with valid/ready handshake and a
// two-entry skid buffer so that ready_e comes straight from flops.
module reg_exc_mem_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH     = PIPE_DATA_W,
   parameter int REG_ADDR_WIDTH = PIPE_REG_W
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      valid_e,
   output logic                      ready_e,
   input  logic [DATA_WIDTH-1:0]     ALUResultE,
   input  logic [DATA_WIDTH-1:0]     WriteDataE,
   input  logic [REG_ADDR_WIDTH-1:0] RdE,
   input  logic [DATA_WIDTH-1:0]     PCPlus4E,
   input  logic                      RegWriteE,
   input  logic                      MemWriteE,
   input  logic [1:0]                ResultSrcE,
   input  logic [2:0]                Funct3E,
   output logic                      valid_m,
   input  logic                      ready_m,
   output logic [DATA_WIDTH-1:0]     ALUResultM,
   output logic [DATA_WIDTH-1:0]     WriteDataM,
   output logic [REG_ADDR_WIDTH-1:0] RdM,
   output logic [DATA_WIDTH-1:0]     PCPlus4M,
   output logic                      RegWriteM,
   output logic                      MemWriteM,
   output logic [1:0]                ResultSrcM,
   output logic [2:0]                Funct3M
);

   state_e   r_state;
   state_e   w_state_next;
   exc_mem_t w_entry_e;
   exc_mem_t w_slot_d [2];
   exc_mem_t w_slot_q [2];
   logic     w_slot_load [2];
   logic     w_head_from_skid;
   logic     w_ready_e;
   logic     w_valid_m;
   logic     w_accept;
   logic     w_pop;

   assign w_entry_e = '{alu_result: ALUResultE, write_data: WriteDataE, rd: RdE,
                        pc_plus4: PCPlus4E, reg_write: RegWriteE, mem_write: MemWriteE,
                        result_src: ResultSrcE, funct3: Funct3E};

   // ready_e and valid_m are pure decodes of the state register
   assign w_ready_e = (r_state != TWO);
   assign w_valid_m = (r_state != EMPTY);
   assign w_accept  = valid_e & w_ready_e;
   assign w_pop     = w_valid_m & ready_m;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: squash empties the stage, otherwise track occupancy
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: if (w_accept) w_state_next = ONE;
            ONE: begin
               if (w_accept && !w_pop)      w_state_next = TWO;
               else if (w_pop && !w_accept) w_state_next = EMPTY;
            end
            TWO:   if (w_pop) w_state_next = ONE;
            default: w_state_next = EMPTY;
         endcase
      end
   end

   // Slot load enables and head source select; a squash suppresses all loads
   always_comb begin
      w_slot_load[0]   = 1'b0;
      w_slot_load[1]   = 1'b0;
      w_head_from_skid = 1'b0;
      if (!flush) begin
         case (r_state)
            EMPTY: w_slot_load[0] = w_accept;
            ONE: begin
               w_slot_load[0] = w_accept & w_pop;
               w_slot_load[1] = w_accept & ~w_pop;
            end
            TWO: begin
               w_slot_load[0]   = w_pop;
               w_head_from_skid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign w_slot_d[0] = w_head_from_skid ? w_slot_q[1] : w_entry_e;
   assign w_slot_d[1] = w_entry_e;

   // Slot 0 is the head (drives the M side), slot 1 is the skid entry
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         exc_mem_slot u_slot (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_slot_load[gi]),
            .i_clr_ctrl (flush),
            .i_d        (w_slot_d[gi]),
            .o_q        (w_slot_q[gi])
         );
      end
   endgenerate

   assign ready_e    = w_ready_e;
   assign valid_m    = w_valid_m;
   assign ALUResultM = w_slot_q[0].alu_result;
   assign WriteDataM = w_slot_q[0].write_data;
   assign RdM        = w_slot_q[0].rd;
   assign PCPlus4M   = w_slot_q[0].pc_plus4;
   assign ResultSrcM = w_slot_q[0].result_src;
   assign Funct3M    = w_slot_q[0].funct3;
   // A stale head must never cause a register or memory write
   assign RegWriteM  = w_slot_q[0].reg_write & w_valid_m;
   assign MemWriteM  = w_slot_q[0].mem_write & w_valid_m;

endmodule

// File: tb/tb_reg_exc_mem_elastic.sv
// Bench for reg_exc_mem_elastic: directed scenarios followed by random traffic,
// all checked against a capacity-2 FIFO model.
module tb_reg_exc_mem_elastic;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, valid_e, ready_m;
   logic        ready_e, valid_m;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   exc_mem_t    cur_e;

   int n_cmp = 0;
   int n_bad = 0;
   exc_mem_t model_q[$];

   always #5 clk = ~clk;

   reg_exc_mem_elastic #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset), .flush(flush), .valid_e(valid_e), .ready_e(ready_e),
      .ALUResultE(cur_e.alu_result), .WriteDataE(cur_e.write_data), .RdE(cur_e.rd),
      .PCPlus4E(cur_e.pc_plus4), .RegWriteE(cur_e.reg_write), .MemWriteE(cur_e.mem_write),
      .ResultSrcE(cur_e.result_src), .Funct3E(cur_e.funct3),
      .valid_m(valid_m), .ready_m(ready_m),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exc_mem_t rnd_entry();
      exc_mem_t e;
      e.alu_result = $urandom;
      e.write_data = $urandom;
      e.rd         = 5'($urandom_range(0, 31));
      e.pc_plus4   = $urandom;
      e.reg_write  = 1'($urandom_range(0, 1));
      e.mem_write  = 1'($urandom_range(0, 1));
      e.result_src = 2'($urandom_range(0, 2));
      e.funct3     = 3'($urandom_range(0, 7));
      return e;
   endfunction

   // Model: a FIFO of at most two instructions
   task automatic model_update();
      int  n;
      bit  do_pop, do_push;
      if (reset || flush) begin
         model_q.delete();
      end else begin
         n       = model_q.size();
         do_pop  = (n > 0) && ready_m;
         do_push = valid_e && (n < 2);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(cur_e);
      end
   endtask

   task automatic compare_outputs();
      check_val("ready_e", 32'(ready_e), 32'(model_q.size() < 2));
      check_val("valid_m", 32'(valid_m), 32'(model_q.size() > 0));
      if (model_q.size() > 0) begin
         check_val("alu",  ALUResultM, model_q[0].alu_result);
         check_val("wdat", WriteDataM, model_q[0].write_data);
         check_val("rd",   32'(RdM), 32'(model_q[0].rd));
         check_val("pc4",  PCPlus4M, model_q[0].pc_plus4);
         check_val("rsrc", 32'(ResultSrcM), 32'(model_q[0].result_src));
         check_val("f3",   32'(Funct3M), 32'(model_q[0].funct3));
         check_val("regw", 32'(RegWriteM), 32'(model_q[0].reg_write));
         check_val("memw", 32'(MemWriteM), 32'(model_q[0].mem_write));
      end else begin
         check_val("regw_idle", 32'(RegWriteM), 32'd0);
         check_val("memw_idle", 32'(MemWriteM), 32'd0);
      end
   endtask

   // One clock: model and DUT advance on the same edge, outputs checked mid-cycle
   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, 32'(valid_m), 32'd0);
      check_val({tag, "_ready"}, 32'(ready_e), 32'd1);
      check_val({tag, "_data"},  ALUResultM | WriteDataM | PCPlus4M | 32'(RdM)
                                 | 32'(ResultSrcM) | 32'(Funct3M), 32'd0);
      check_val({tag, "_ctrl"},  32'({RegWriteM, MemWriteM}), 32'd0);
   endtask

   initial begin
      exc_mem_t ea, eb, ec;
      reset = 1'b1; flush = 1'b0; valid_e = 1'b0; ready_m = 1'b0;
      cur_e = rnd_entry();
      tick(); tick();
      check_all_zero("rst");
      reset = 1'b0;

      // Back-to-back stream with the Memory stage always ready
      ready_m = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cur_e = rnd_entry();
         cur_e.alu_result = 32'((i + 1) * 16);
         valid_e = 1'b1;
         tick();
         check_val("stream_alu", ALUResultM, 32'((i + 1) * 16));
         check_val("stream_rdy", 32'(ready_e), 32'd1);
      end
      valid_e = 1'b0;
      tick();
      $display("stream done: compared=%0d", n_cmp);

      // Back-pressure: two absorbed, third held by Execute
      ready_m = 1'b0;
      ea = rnd_entry(); ea.alu_result = 32'hA;
      eb = rnd_entry(); eb.alu_result = 32'hB;
      ec = rnd_entry(); ec.alu_result = 32'hC;
      valid_e = 1'b1;
      cur_e = ea; tick();
      cur_e = eb; tick();
      check_val("bp_ready_low", 32'(ready_e), 32'd0);
      cur_e = ec; tick();
      check_val("bp_head_hold", ALUResultM, 32'hA);
      ready_m = 1'b1;
      tick();
      check_val("bp_pop_b", ALUResultM, 32'hB);
      tick();
      check_val("bp_pop_c", ALUResultM, 32'hC);
      valid_e = 1'b0;
      tick();
      check_val("bp_drained", 32'(valid_m), 32'd0);
      $display("backpressure done: compared=%0d", n_cmp);

      // Flush while full
      ready_m = 1'b0; valid_e = 1'b1;
      cur_e = rnd_entry(); cur_e.mem_write = 1'b1; tick();
      cur_e = rnd_entry(); cur_e.reg_write = 1'b1; tick();
      check_val("fl_two", 32'(ready_e), 32'd0);
      valid_e = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("fl_valid", 32'(valid_m), 32'd0);
      check_val("fl_ctrl", 32'({RegWriteM, MemWriteM}), 32'd0);
      check_val("fl_ready", 32'(ready_e), 32'd1);
      $display("flush-in-two done: compared=%0d", n_cmp);

      // Flush coincides with an accept of Rd 7
      cur_e = rnd_entry(); cur_e.rd = 5'd7; cur_e.reg_write = 1'b1;
      valid_e = 1'b1; flush = 1'b1; ready_m = 1'b1;
      tick();
      flush = 1'b0; valid_e = 1'b0;
      check_val("fa_valid", 32'(valid_m), 32'd0);
      tick();
      check_val("fa_valid2", 32'(valid_m), 32'd0);
      $display("flush+accept done: compared=%0d", n_cmp);

      // Popped head with RegWrite set must not look like a write afterwards
      cur_e = rnd_entry(); cur_e.reg_write = 1'b1; cur_e.mem_write = 1'b1;
      valid_e = 1'b1; ready_m = 1'b0;
      tick();
      check_val("gate_live", 32'(RegWriteM), 32'd1);
      valid_e = 1'b0; ready_m = 1'b1;
      tick();
      check_val("gate_regw", 32'(RegWriteM), 32'd0);
      check_val("gate_memw", 32'(MemWriteM), 32'd0);
      $display("gating done: compared=%0d", n_cmp);

      // Reset while holding one entry with Execute still offering one
      cur_e = rnd_entry(); valid_e = 1'b1; ready_m = 1'b0;
      tick();
      cur_e = rnd_entry(); reset = 1'b1;
      tick();
      check_all_zero("rst_one");
      reset = 1'b0; valid_e = 1'b0;
      tick();
      check_val("rst_nocap", 32'(valid_m), 32'd0);
      $display("reset-in-one done: compared=%0d", n_cmp);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         cur_e   = rnd_entry();
         valid_e = ($urandom_range(0, 9) < 7);
         ready_m = ($urandom_range(0, 9) < 6);
         flush   = ($urandom_range(0, 31) == 0);
         reset   = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0; flush = 1'b0; valid_e = 1'b0;
      $display("random done: compared=%0d", n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
